// File: rtl/lsu_stb_cnt_ctl.sv
// Per-thread store-buffer occupancy tracker for one core (4 threads).
// Tracks enqueue/dequeue of stores per thread and keeps the RAM write/read
// pointers and the occupancy counts. These feed IFU thread switching and
// the store-buffer overflow checker.
//
// Ports:
//   clk, reset                       core clock; async active-high reset
//   stb_enq_vld, stb_enq_tid         one store enqueue per cycle, tagged by thread
//   stb_deq_vld[3:0]                 per-thread dequeue (PCX ack)
//   stb_flush[3:0]                   per-thread flush, wins over enq/deq
//   lsu_ifu_stbcnt0..3               per-thread occupancy, 0..DEPTH
//   stb_wptr0..3, stb_rptr0..3       per-thread RAM write/read pointers
//   stb_full, stb_empty              per-thread count==DEPTH / count==0
//   stb_ctl_reset0..3                flush registered, high one cycle
//   stb_ovfl_err, stb_udfl_err       sticky enqueue-on-full / dequeue-on-empty
module lsu_stb_cnt_ctl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNTW  = 4,
    parameter int unsigned PTRW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stb_enq_vld,
    input  logic [1:0]      stb_enq_tid,
    input  logic [3:0]      stb_deq_vld,
    input  logic [3:0]      stb_flush,
    output logic [CNTW-1:0] lsu_ifu_stbcnt0,
    output logic [CNTW-1:0] lsu_ifu_stbcnt1,
    output logic [CNTW-1:0] lsu_ifu_stbcnt2,
    output logic [CNTW-1:0] lsu_ifu_stbcnt3,
    output logic [PTRW-1:0] stb_wptr0,
    output logic [PTRW-1:0] stb_wptr1,
    output logic [PTRW-1:0] stb_wptr2,
    output logic [PTRW-1:0] stb_wptr3,
    output logic [PTRW-1:0] stb_rptr0,
    output logic [PTRW-1:0] stb_rptr1,
    output logic [PTRW-1:0] stb_rptr2,
    output logic [PTRW-1:0] stb_rptr3,
    output logic [3:0]      stb_full,
    output logic [3:0]      stb_empty,
    output logic            stb_ctl_reset0,
    output logic            stb_ctl_reset1,
    output logic            stb_ctl_reset2,
    output logic            stb_ctl_reset3,
    output logic [3:0]      stb_ovfl_err,
    output logic [3:0]      stb_udfl_err
);

    localparam int unsigned NT = 4;

    logic [CNTW-1:0] cnt_q  [NT];
    logic [CNTW-1:0] cnt_d  [NT];
    logic [PTRW-1:0] wptr_q [NT];
    logic [PTRW-1:0] wptr_d [NT];
    logic [PTRW-1:0] rptr_q [NT];
    logic [PTRW-1:0] rptr_d [NT];
    logic [NT-1:0]   full_q, full_d;
    logic [NT-1:0]   empty_q, empty_d;
    logic [NT-1:0]   crst_q;
    logic [NT-1:0]   ovfl_q, ovfl_d;
    logic [NT-1:0]   udfl_q, udfl_d;
    logic [NT-1:0]   enq_c;
    logic [NT-1:0]   deq_c;

    // Per-thread enqueue/dequeue strobes.
    always_comb begin
        enq_c = '0;
        for (int t = 0; t < NT; t++) begin
            enq_c[t] = stb_enq_vld && (stb_enq_tid == 2'(t));
        end
        deq_c = stb_deq_vld;
    end

    // Next-state for counts, pointers and sticky errors; flush wins.
    always_comb begin
        ovfl_d = ovfl_q;
        udfl_d = udfl_q;
        full_d = '0;
        empty_d = '0;
        for (int t = 0; t < NT; t++) begin
            cnt_d[t]  = cnt_q[t];
            wptr_d[t] = wptr_q[t];
            rptr_d[t] = rptr_q[t];
            if (stb_flush[t]) begin
                cnt_d[t]  = '0;
                wptr_d[t] = '0;
                rptr_d[t] = '0;
            end else if (enq_c[t] && deq_c[t]) begin
                if (cnt_q[t] == '0) begin
                    // Nothing to dequeue yet: only the enqueue takes effect.
                    cnt_d[t]  = CNTW'(1);
                    wptr_d[t] = wptr_q[t] + PTRW'(1);
                    udfl_d[t] = 1'b1;
                end else begin
                    // Also covers full: the dequeue frees the slot the enqueue uses.
                    wptr_d[t] = wptr_q[t] + PTRW'(1);
                    rptr_d[t] = rptr_q[t] + PTRW'(1);
                end
            end else if (enq_c[t]) begin
                if (cnt_q[t] == CNTW'(DEPTH)) begin
                    ovfl_d[t] = 1'b1;
                end else begin
                    cnt_d[t]  = cnt_q[t] + CNTW'(1);
                    wptr_d[t] = wptr_q[t] + PTRW'(1);
                end
            end else if (deq_c[t]) begin
                if (cnt_q[t] == '0) begin
                    udfl_d[t] = 1'b1;
                end else begin
                    cnt_d[t]  = cnt_q[t] - CNTW'(1);
                    rptr_d[t] = rptr_q[t] + PTRW'(1);
                end
            end
            full_d[t]  = (cnt_d[t] == CNTW'(DEPTH));
            empty_d[t] = (cnt_d[t] == '0);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NT; t++) begin
                cnt_q[t]  <= '0;
                wptr_q[t] <= '0;
                rptr_q[t] <= '0;
            end
            full_q  <= '0;
            empty_q <= '1;
            crst_q  <= '0;
            ovfl_q  <= '0;
            udfl_q  <= '0;
        end else begin
            for (int t = 0; t < NT; t++) begin
                cnt_q[t]  <= cnt_d[t];
                wptr_q[t] <= wptr_d[t];
                rptr_q[t] <= rptr_d[t];
            end
            full_q  <= full_d;
            empty_q <= empty_d;
            crst_q  <= stb_flush;
            ovfl_q  <= ovfl_d;
            udfl_q  <= udfl_d;
        end
    end

    assign lsu_ifu_stbcnt0 = cnt_q[0];
    assign lsu_ifu_stbcnt1 = cnt_q[1];
    assign lsu_ifu_stbcnt2 = cnt_q[2];
    assign lsu_ifu_stbcnt3 = cnt_q[3];
    assign stb_wptr0       = wptr_q[0];
    assign stb_wptr1       = wptr_q[1];
    assign stb_wptr2       = wptr_q[2];
    assign stb_wptr3       = wptr_q[3];
    assign stb_rptr0       = rptr_q[0];
    assign stb_rptr1       = rptr_q[1];
    assign stb_rptr2       = rptr_q[2];
    assign stb_rptr3       = rptr_q[3];
    assign stb_full        = full_q;
    assign stb_empty       = empty_q;
    assign stb_ctl_reset0  = crst_q[0];
    assign stb_ctl_reset1  = crst_q[1];
    assign stb_ctl_reset2  = crst_q[2];
    assign stb_ctl_reset3  = crst_q[3];
    assign stb_ovfl_err    = ovfl_q;
    assign stb_udfl_err    = udfl_q;

endmodule
